// File: rtl/matrd_stream_if.sv
// Handshake bundle for matrd_stream: parallel matrix capture side and
// element-wise valid/ready output stream.
interface matrd_stream_if #(
    parameter int unsigned rsize  = 2,
    parameter int unsigned csize  = 3,
    parameter int unsigned dwidth = 32
);
    localparam int unsigned rw = (rsize > 1) ? $clog2(rsize) : 1;
    localparam int unsigned cw = (csize > 1) ? $clog2(csize) : 1;

    logic [rsize-1:0][csize-1:0][dwidth-1:0] mat;
    logic                                    mat_valid;
    logic                                    mat_ready;
    logic [dwidth-1:0]                       out_data;
    logic [rw-1:0]                           out_row;
    logic [cw-1:0]                           out_col;
    logic                                    out_eol;
    logic                                    out_last;
    logic                                    out_valid;
    logic                                    out_ready;
    logic                                    busy;

    // Producer of matrices / consumer of elements.
    modport master (
        output mat, mat_valid, out_ready,
        input  mat_ready, out_data, out_row, out_col, out_eol, out_last, out_valid, busy
    );

    // The streamer itself.
    modport slave (
        input  mat, mat_valid, out_ready,
        output mat_ready, out_data, out_row, out_col, out_eol, out_last, out_valid, busy
    );
endinterface

// File: rtl/matrd_stream.sv
// Captures a whole rsize x csize matrix in one cycle, then emits it
// row-major, one element per valid/ready handshake, with row/col indices
// and end-of-row / end-of-matrix flags.
module matrd_stream #(
    parameter int unsigned rsize  = 2,
    parameter int unsigned csize  = 3,
    parameter int unsigned dwidth = 32
) (
    input logic        clk,
    input logic        rst_n,
    matrd_stream_if.slave bus
);
    localparam int unsigned rw = (rsize > 1) ? $clog2(rsize) : 1;
    localparam int unsigned cw = (csize > 1) ? $clog2(csize) : 1;

    typedef enum logic {StIdle, StStream} state_e;

    state_e                                  state_q, state_d;
    logic [rw-1:0]                           row_q, row_nx;
    logic [cw-1:0]                           col_q, col_nx;
    logic [dwidth-1:0]                       data_q;
    logic [rsize-1:0][csize-1:0][dwidth-1:0] buf_q;
    logic                                    capture;
    logic                                    xfer;
    logic                                    col_end;
    logic                                    row_end;

    assign capture = (state_q == StIdle) && bus.mat_valid;
    assign xfer    = (state_q == StStream) && bus.out_ready;
    assign col_end = (col_q == cw'(csize - 1));
    assign row_end = (row_q == rw'(rsize - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on capture, return after the last element is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.mat_valid) state_d = StStream;
            StStream: if (xfer && col_end && row_end) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Position of the element following the current one (row-major walk).
    always_comb begin
        row_nx = row_q;
        col_nx = col_q + 1'b1;
        if (col_end) begin
            row_nx = row_q + 1'b1;
            col_nx = '0;
        end
    end

    // Matrix buffer; contents are only meaningful after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= bus.mat;
        end
    end

    // Index and element registers; data is fetched on the same edge as the index moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            data_q <= '0;
        end else if (capture) begin
            row_q  <= '0;
            col_q  <= '0;
            data_q <= bus.mat[0][0];
        end else if (xfer) begin
            if (col_end && row_end) begin
                row_q <= '0;
                col_q <= '0;
            end else begin
                row_q  <= row_nx;
                col_q  <= col_nx;
                data_q <= buf_q[row_nx][col_nx];
            end
        end
    end

    // Outputs; flags are gated by STREAM so an idle block never shows eol/last.
    always_comb begin
        bus.mat_ready = (state_q == StIdle);
        bus.busy      = (state_q == StStream);
        bus.out_valid = (state_q == StStream);
        bus.out_data  = data_q;
        bus.out_row   = row_q;
        bus.out_col   = col_q;
        bus.out_eol   = (state_q == StStream) && col_end;
        bus.out_last  = (state_q == StStream) && col_end && row_end;
    end
endmodule

// File: doc/matrd_stream.md
Name: matrd_stream

Overview:
- Reader side of the matrix-adder result interface.
- Captures one full rsize x csize matrix of dwidth-bit elements in a single cycle, then emits it one element per handshake, row-major, on a valid/ready stream.
- Each element carries row/column indices and end-of-row/end-of-matrix flags.
- Sits between the parallel matrix adder output and narrow downstream consumers (memory writer, serial link).

Parameters:
- rsize, 2, number of matrix rows (>=1)
- csize, 3, number of matrix columns (>=1)
- dwidth, 32, element width in bits
- rw, derived: max(1, clog2(rsize)), row index width
- cw, derived: max(1, clog2(csize)), column index width

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- mat  input  dwidth x [rsize][csize]  parallel matrix, indexed [row][col]
- mat_valid  input  1  mat holds a complete matrix this cycle
- mat_ready  output  1  block idle and able to capture
- out_data  output  dwidth  current element
- out_row  output  rw  row index of out_data
- out_col  output  cw  column index of out_data
- out_eol  output  1  out_col == csize-1
- out_last  output  1  final element of the matrix
- out_valid  output  1  out_* fields valid
- out_ready  input  1  downstream accepts element
- busy  output  1  matrix captured and not yet fully drained (= ~mat_ready)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, named rst_n.
- Reset values:
  - state=IDLE, mat_ready=1, busy=0, out_valid=0.
  - out_data=0, out_row=0, out_col=0, out_eol=0, out_last=0.
  - Internal buffer contents: don't-care.
- States: IDLE, STREAM.
- IDLE:
  - mat_ready=1.
  - On mat_valid=1, copy all elements of mat into the internal buffer in one cycle and go to STREAM.
  - In the next cycle: out_valid=1, row=0, col=0, out_data=buf[0][0].
  - Capture-to-first-valid latency: 1 cycle.
- STREAM:
  - mat_ready=0; mat_valid is ignored and mat is not sampled.
  - A transfer occurs when out_valid && out_ready.
  - While out_ready=0, all out_* fields hold stable; out_valid is never deasserted without a transfer.
  - On a transfer of a non-last element:
    - Column increments; on col==csize-1, col wraps to 0 and row increments.
    - out_data updates from the buffer in the same edge, so a new element is valid the next cycle.
    - Full throughput: 1 element/cycle with out_ready held high.
  - On transfer of the last element (row==rsize-1, col==csize-1):
    - Next cycle: out_valid=0, row/col=0, state=IDLE, mat_ready=1.
- Outputs are registered, combinational on state/index:
  - out_eol = (col==csize-1).
  - out_last = out_eol && (row==rsize-1).
- Throughput: one matrix per rsize*csize+1 cycles minimum (one IDLE capture cycle between matrices). No back-to-back overlap.
- Boundaries:
  - rsize=csize=1: first element has out_eol=1 and out_last=1; returns to IDLE after one transfer.
  - Non-power-of-2 dimensions: indices never exceed csize-1 / rsize-1.
  - mat changing during STREAM has no effect on emitted data.
  - rst_n asserted mid-stream: immediate return to reset values. The partial matrix is discarded, with no resumption after reset.
  - mat_valid and rst_n release in the same edge: not captured. Capture requires rst_n high at the sampling edge.

Test Plan:
- Reset, rsize=2, csize=3, mat[i][j]=16*i+j+1, pulse mat_valid, out_ready=1:
  - Elements 1,2,3,17,18,19 on 6 consecutive cycles starting 1 cycle after capture.
  - out_eol on 3 and 19; out_last only on 19.
  - mat_ready high again on the cycle after 19.
- Same matrix, out_ready toggling 1,0,0,1,...: each element held stable while out_ready=0; no duplicates or drops; order and indices (0,0)..(1,2) unchanged.
- During STREAM:
  - Drive mat to all 0xDEADBEEF with mat_valid=1 → ignored, the original values are emitted.
  - After out_last, a new mat_valid is captured and the stream restarts at (0,0).
- Assert rst_n=0 asynchronously after the 3rd transfer:
  - out_valid drops without waiting for a clock; mat_ready=1.
  - Next matrix (all 0x5) streams from (0,0) with six 0x5 elements.
- rsize=1, csize=1, mat=0x12345678: single element with out_eol=out_last=1; mat_ready back to 1 two cycles after capture.
- rsize=3, csize=5, out_ready=1, random data:
  - 15 elements in row-major order; col wraps 4→0, row 0→1→2.
  - Exactly 16 cycles from capture to mat_ready re-assertion.
